// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: paces XADC conversions at SAMPLE_HZ and forwards one sample per tick.
// Optional ADC_AVG_EN: four back-to-back conversions per tick, averaged into one sample.
module adc_sample_sequencer #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned SAMPLE_HZ   = 360,
  parameter int unsigned DATA_W      = 11,
  parameter int unsigned CONVST_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr_err,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_adc_data_rdy,
  input  logic              i_adc_busy,
  output logic              o_adc_convst,
  output logic              o_adc_en,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_sample_vld,
  output logic              o_overrun,
  output logic              o_timeout
);

  localparam int unsigned PERIOD = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned TickW  = $clog2(PERIOD);
  localparam int unsigned CvW    = (CONVST_CYC > 1) ? $clog2(CONVST_CYC) : 1;
  localparam int unsigned ToW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StConvst,
    StWaitBusy,
    StWaitData
  } state_e;

  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [CvW-1:0]    cv_cnt_q, cv_cnt_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              convst_q, adc_en_q;
  logic              vld_q, vld_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] sample_q, sample_d;

  logic              tick, cv_done, to_expire, handshake;
  logic              overrun_set, timeout_set, last_conv;
  logic [DATA_W-1:0] conv_sample;

  assign tick      = i_en && (tick_cnt_q == TickW'(PERIOD - 1));
  assign cv_done   = (cv_cnt_q == CvW'(CONVST_CYC - 1));
  assign to_expire = (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
  assign handshake = (state_q == StWaitData) && adc_en_q && i_adc_data_rdy;

  always_comb begin
    tick_cnt_d = tick_cnt_q + TickW'(1);
    if (!i_en || tick) tick_cnt_d = '0;
  end

  // Both counters idle at zero outside their states, so entry always starts a fresh count.
  always_comb begin
    cv_cnt_d = '0;
    to_cnt_d = '0;
    if (state_q == StConvst) cv_cnt_d = cv_cnt_q + CvW'(1);
    if (state_q == StWaitBusy || state_q == StWaitData) to_cnt_d = to_cnt_q + ToW'(1);
  end

`ifdef ADC_AVG_EN
  logic [DATA_W+1:0] acc_q, acc_d, acc_sum;
  logic [1:0]        conv_idx_q, conv_idx_d;

  assign acc_sum     = acc_q + {2'b00, i_adc_data};
  assign last_conv   = (conv_idx_q == 2'd3);
  assign conv_sample = acc_sum[DATA_W+1:2];

  always_comb begin
    acc_d      = acc_q;
    conv_idx_d = conv_idx_q;
    if (state_q == StWaitTick) begin
      acc_d      = '0;
      conv_idx_d = '0;
    end else if (handshake) begin
      acc_d      = acc_sum;
      conv_idx_d = conv_idx_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q      <= '0;
      conv_idx_q <= '0;
    end else begin
      acc_q      <= acc_d;
      conv_idx_q <= conv_idx_d;
    end
  end
`else
  assign last_conv   = 1'b1;
  assign conv_sample = i_adc_data;
`endif

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    vld_d       = 1'b0;
    overrun_set = 1'b0;
    timeout_set = 1'b0;
    if (!i_en) begin
      state_d = StIdle;
    end else begin
      overrun_set = tick && (state_q != StWaitTick);
      unique case (state_q)
        StIdle:     state_d = StWaitTick;
        StWaitTick: if (tick) state_d = StConvst;
        StConvst:   if (cv_done) state_d = StWaitBusy;
        StWaitBusy: begin
          if (to_expire) begin
            state_d     = StWaitTick;
            timeout_set = 1'b1;
          end else if (i_adc_busy) begin
            state_d = StWaitData;
          end
        end
        StWaitData: begin
          // A word landing in the last allowed cycle still counts.
          if (handshake) begin
            if (last_conv) begin
              sample_d = conv_sample;
              vld_d    = 1'b1;
              state_d  = StWaitTick;
            end else begin
              state_d = StConvst;
            end
          end else if (to_expire) begin
            state_d     = StWaitTick;
            timeout_set = 1'b1;
          end
        end
        default:    state_d = StIdle;
      endcase
    end
    overrun_d = overrun_set | (overrun_q & ~i_clr_err);
    timeout_d = timeout_set | (timeout_q & ~i_clr_err);
  end

  // Handshake outputs are registered from the next state so they stay aligned with state_q.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      cv_cnt_q   <= '0;
      to_cnt_q   <= '0;
      convst_q   <= 1'b0;
      adc_en_q   <= 1'b0;
      vld_q      <= 1'b0;
      sample_q   <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cv_cnt_q   <= cv_cnt_d;
      to_cnt_q   <= to_cnt_d;
      convst_q   <= (state_d == StConvst);
      adc_en_q   <= (state_d == StIdle) || (state_d == StWaitData);
      vld_q      <= vld_d;
      sample_q   <= sample_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_adc_convst = convst_q;
  assign o_adc_en     = adc_en_q;
  assign o_sample     = sample_q;
  assign o_sample_vld = vld_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule
